alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter ALU_LAT, default 2, cycles from ALU load to valid alu_out (>=1).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  synchronous clear of FIFO, FSM and result slot.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  FIFO can accept.
REQ-008 cmd_num1, cmd_num2  in  8 each  operands.
REQ-009 cmd_op  in  7  one-hot ALU operation.
REQ-010 alu_on  out  1  ALU enable.
REQ-011 alu_in_sel  out  3  ALU control: 100 persist, 010 load, 001 reset.
REQ-012 alu_num1, alu_num2  out  8 each  operands to ALU.
REQ-013 alu_out_sel  out  7  operation to ALU.
REQ-014 alu_out  in  8  ALU result.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts.
REQ-017 res_data  out  8  result; res_err  out  1  illegal-op flag.
REQ-018 fifo_count  out  clog2(DEPTH+1)  occupancy.

Function
REQ-019 Command accepted when cmd_valid && cmd_ready; cmd_ready = (fifo_count < DEPTH) && !flush.
REQ-020 FIFO first-in-first-out, pointers wrap modulo DEPTH; simultaneous push and pop when full or empty is legal, count unchanged when both occur.
REQ-021 FSM states IDLE, LOAD, HOLD, DRAIN.
REQ-022 IDLE: alu_on=0, alu_in_sel=001, alu_num1/num2/out_sel=0; if FIFO non-empty and head op one-hot -> LOAD; if head op not one-hot (including zero) -> pop, res_data=0, res_err=1 -> DRAIN.
REQ-023 LOAD: exactly one cycle, alu_on=1, alu_in_sel=010, alu_num1/num2/out_sel = FIFO head; head popped at end of cycle; counter loaded with ALU_LAT-1; -> HOLD.
REQ-024 HOLD: alu_on=1, alu_in_sel=100, operands/op held from LOAD; when counter==0 capture alu_out into res_data, res_err=0, -> DRAIN; else decrement.
REQ-025 DRAIN: res_valid=1, res_data/res_err stable; on res_ready -> IDLE; ALU kept in persist.
REQ-026 Latency push-to-res_valid on empty FIFO: 1 (FIFO) + 1 (LOAD) + ALU_LAT cycles.
REQ-027 Only one command in flight; next LOAD never starts before current result accepted.
REQ-028 flush overrides all: FIFO emptied, FSM -> IDLE, res_valid=0 next cycle; a simultaneous push is dropped.
REQ-029 res_valid never deasserts without res_ready, except on flush or reset.

Reset
REQ-030 rst low: FIFO empty, fifo_count=0, FSM IDLE, counter 0, res_valid=0, res_data=0, res_err=0, alu_on=0, alu_in_sel=001, alu operands/op=0, cmd_ready=0 while asserted.
REQ-031 Reset mid-operation discards in-flight and queued commands; no result emitted.

Structure
REQ-032 Shared package holds in_sel encodings (PERSIST, LOAD, RESET), FSM state enum, operand width 8, op width 7.
REQ-033 One sub-module: cmd_fifo (parameterised DEPTH, 23-bit entries); FSM and result slot in top.

Verification (bench ALU model: op 1000000 = add, 0100000 = subtract, latency ALU_LAT)
REQ-034 Push 0x57,0x1A,op 1000000 into empty block -> alu_in_sel 010 one cycle then 100; res_valid after 1+1+2 cycles, res_data=0x71, res_err=0.
REQ-035 Push 5 commands back-to-back with res_ready=0 -> cmd_ready low after 4th stored (one popped in flight: 5th accepted), 6th stalls; results emerge in order when res_ready raised.
REQ-036 Push op 0000000 then op 0000011 -> two results res_data=0, res_err=1, no alu_in_sel 010 cycle.
REQ-037 Assert rst during HOLD with 2 queued -> all outputs at reset values asynchronously; no result after release.
REQ-038 flush with cmd_valid high and FIFO full -> fifo_count=0 next cycle, res_valid=0, pushed command lost.
REQ-039 Push 0x02,0x04 op 0100000 with res_ready tied high continuously -> res_data=0xFE, res_valid exactly one cycle per command.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and encodings for the ALU command sequencer: operand/op widths,
// ALU input-select codes, FSM state enum and the queued command layout.
package alu_cmd_sequencer_pkg;

  localparam int OPND_W = 8;
  localparam int OP_W   = 7;
  localparam int CMD_W  = 2 * OPND_W + OP_W;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [OPND_W-1:0] num1;
    logic [OPND_W-1:0] num2;
    logic [OP_W-1:0]   op;
  } cmd_t;

  // Exactly one bit set; an all-zero op is illegal too.
  function automatic logic isOneHot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - OP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result channels of the sequencer; slave is the sequencer,
// master is whoever issues commands, hosts the ALU and consumes results.
interface alu_cmd_sequencer_if;

  logic                                    cmd_valid;
  logic                                    cmd_ready;
  logic [alu_cmd_sequencer_pkg::OPND_W-1:0] cmd_num1;
  logic [alu_cmd_sequencer_pkg::OPND_W-1:0] cmd_num2;
  logic [alu_cmd_sequencer_pkg::OP_W-1:0]   cmd_op;

  logic                                    alu_on;
  logic [2:0]                              alu_in_sel;
  logic [alu_cmd_sequencer_pkg::OPND_W-1:0] alu_num1;
  logic [alu_cmd_sequencer_pkg::OPND_W-1:0] alu_num2;
  logic [alu_cmd_sequencer_pkg::OP_W-1:0]   alu_out_sel;
  logic [alu_cmd_sequencer_pkg::OPND_W-1:0] alu_out;

  logic                                    res_valid;
  logic                                    res_ready;
  logic [alu_cmd_sequencer_pkg::OPND_W-1:0] res_data;
  logic                                    res_err;

  modport master (
    output cmd_valid, cmd_num1, cmd_num2, cmd_op,
    input  cmd_ready,
    input  alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
    output alu_out,
    input  res_valid, res_data, res_err,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_num1, cmd_num2, cmd_op,
    output cmd_ready,
    output alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
    input  alu_out,
    output res_valid, res_data, res_err,
    input  res_ready
  );

endinterface

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Circular command FIFO of DEPTH 23-bit entries with combinational head,
// occupancy count and a synchronous flush that empties it.
module alu_cmd_sequencer_cmd_fifo
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [CMD_W-1:0]             i_pushData,
  input  logic                         i_pop,
  output logic [CMD_W-1:0]             o_headData,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_doPop    = i_pop && !o_empty;
  assign w_doPush   = i_push && (!w_full || w_doPop);
  assign o_headData = r_mem[r_rdPtr];
  assign o_count    = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives one at a time through an external ALU with fixed
// latency and holds each result (or illegal-op error) until the consumer takes it.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_flush,
  output logic [$clog2(DEPTH+1)-1:0]  o_fifo_count,
  alu_cmd_sequencer_if.slave          bus
);

  localparam int CNT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  state_t            r_state;
  state_t            w_nextState;
  cmd_t              w_head;
  cmd_t              w_pushData;
  cmd_t              r_held;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_headLegal;
  logic              w_cmdReady;
  logic [CNT_W-1:0]  r_cnt;
  logic [OPND_W-1:0] r_resData;
  logic              r_resErr;

  assign w_pushData  = {bus.cmd_num1, bus.cmd_num2, bus.cmd_op};
  assign w_headLegal = isOneHot(w_head.op);
  assign w_cmdReady  = rst_n && !i_flush && (o_fifo_count < FCNT_W'(DEPTH));
  assign w_push      = bus.cmd_valid && w_cmdReady;
  // Legal heads leave the queue at the end of LOAD, illegal ones straight from IDLE.
  assign w_pop       = (r_state == ST_LOAD) ||
                       ((r_state == ST_IDLE) && !w_empty && !w_headLegal);

  alu_cmd_sequencer_cmd_fifo #(.DEPTH(DEPTH)) u_cmdFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (i_flush),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_headData (w_head),
    .o_count    (o_fifo_count),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_state <= ST_IDLE;
    else if (i_flush) r_state <= ST_IDLE;
    else              r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_nextState = w_headLegal ? ST_LOAD : ST_DRAIN;
      ST_LOAD:  w_nextState = ST_HOLD;
      ST_HOLD:  if (r_cnt == '0) w_nextState = ST_DRAIN;
      ST_DRAIN: if (bus.res_ready) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Latency counter, operand hold register and result slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_held    <= '0;
      r_resData <= '0;
      r_resErr  <= 1'b0;
    end else if (i_flush) begin
      r_cnt     <= '0;
      r_held    <= '0;
      r_resData <= '0;
      r_resErr  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && !w_headLegal) begin
            r_resData <= '0;
            r_resErr  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_cnt  <= CNT_W'(ALU_LAT - 1);
          r_held <= w_head;
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_resData <= bus.alu_out;
            r_resErr  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.alu_on      = 1'b0;
    bus.alu_in_sel  = SEL_RESET;
    bus.alu_num1    = '0;
    bus.alu_num2    = '0;
    bus.alu_out_sel = '0;
    case (r_state)
      ST_LOAD: begin
        bus.alu_on      = 1'b1;
        bus.alu_in_sel  = SEL_LOAD;
        bus.alu_num1    = w_head.num1;
        bus.alu_num2    = w_head.num2;
        bus.alu_out_sel = w_head.op;
      end
      ST_HOLD, ST_DRAIN: begin
        bus.alu_on      = 1'b1;
        bus.alu_in_sel  = SEL_PERSIST;
        bus.alu_num1    = r_held.num1;
        bus.alu_num2    = r_held.num2;
        bus.alu_out_sel = r_held.op;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = w_cmdReady;
  assign bus.res_valid = (r_state == ST_DRAIN);
  assign bus.res_data  = r_resData;
  assign bus.res_err   = r_resErr;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the sequencer.
module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;
  localparam logic [6:0] OP_ADD = 7'b1000000;
  localparam logic [6:0] OP_SUB = 7'b0100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] fifoCount;
  int         total = 0;
  int         bad = 0;
  bit         chkEn = 1'b0;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (flush),
    .o_fifo_count (fifoCount),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] aluFunc(input logic [6:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // ALU stand-in: result is only presented ALU_LAT edges after a load edge.
  logic [7:0] aluPipe [ALU_LAT];
  logic       aluVld  [ALU_LAT];
  always @(posedge clk) begin
    aluPipe[0] <= aluFunc(bus.alu_out_sel, bus.alu_num1, bus.alu_num2);
    aluVld[0]  <= bus.alu_on && (bus.alu_in_sel == 3'b010);
    for (int i = 1; i < ALU_LAT; i++) begin
      aluPipe[i] <= aluPipe[i-1];
      aluVld[i]  <= aluVld[i-1];
    end
  end
  assign bus.alu_out = aluVld[ALU_LAT-1] ? aluPipe[ALU_LAT-1] : 8'hEE;

  // Transaction-level model: queued commands, one engaged command, one result slot.
  cmd_t       mq[$];
  bit         busy;
  bit         hasRes;
  int         sinceStart;
  cmd_t       cur;
  logic [7:0] mData;
  bit         mErr;

  task automatic modelReset();
    mq.delete();
    busy = 1'b0;
    hasRes = 1'b0;
    sinceStart = 0;
    mData = '0;
    mErr = 1'b0;
  endtask

  task automatic modelStep();
    bit   accept;
    bit   doPop;
    cmd_t c;
    if (!rst_n || flush) begin
      modelReset();
      return;
    end
    accept = bus.cmd_valid && (mq.size() < DEPTH);
    c = {bus.cmd_num1, bus.cmd_num2, bus.cmd_op};
    doPop = 1'b0;
    if (hasRes) begin
      if (bus.res_ready) hasRes = 1'b0;
    end else if (busy) begin
      sinceStart++;
      if (sinceStart == 1) doPop = 1'b1;
      if (sinceStart == 1 + ALU_LAT) begin
        busy = 1'b0;
        hasRes = 1'b1;
        mData = aluFunc(cur.op, cur.num1, cur.num2);
        mErr = 1'b0;
      end
    end else if (mq.size() > 0) begin
      if ($countones(mq[0].op) == 1) begin
        busy = 1'b1;
        sinceStart = 0;
        cur = mq[0];
      end else begin
        doPop = 1'b1;
        hasRes = 1'b1;
        mData = '0;
        mErr = 1'b1;
      end
    end
    if (doPop) void'(mq.pop_front());
    if (accept) mq.push_back(c);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] n1, input logic [7:0] n2,
                               input logic [6:0] op, input logic rr, input logic fl);
    bus.cmd_valid = v;
    bus.cmd_num1  = n1;
    bus.cmd_num2  = n2;
    bus.cmd_op    = op;
    bus.res_ready = rr;
    flush         = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("cmd_ready", bus.cmd_ready, rst_n && !flush && (mq.size() < DEPTH));
      checkOutput("fifo_count", fifoCount, mq.size());
      checkOutput("res_valid", bus.res_valid, hasRes);
      if (hasRes) begin
        checkOutput("res_data", bus.res_data, mData);
        checkOutput("res_err", bus.res_err, mErr);
      end
      if (busy) begin
        checkOutput("alu_on", bus.alu_on, 1'b1);
        checkOutput("alu_in_sel", bus.alu_in_sel, (sinceStart == 0) ? 3'b010 : 3'b100);
        checkOutput("alu_num1", bus.alu_num1, cur.num1);
        checkOutput("alu_num2", bus.alu_num2, cur.num2);
        checkOutput("alu_out_sel", bus.alu_out_sel, cur.op);
      end else if (hasRes) begin
        checkOutput("alu_on", bus.alu_on, 1'b1);
        checkOutput("alu_in_sel", bus.alu_in_sel, 3'b100);
      end else begin
        checkOutput("alu_on", bus.alu_on, 1'b0);
        checkOutput("alu_in_sel", bus.alu_in_sel, 3'b001);
        checkOutput("alu_num1", bus.alu_num1, 8'h00);
        checkOutput("alu_out_sel", bus.alu_out_sel, 7'h00);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int         n;
  int         accepted;
  int         idx;
  int         vldCycles;
  int         loads;
  logic [7:0] got [8];
  logic [7:0] expOrder [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    modelReset();
    checkOutput("reset_count", fifoCount, 0);
    checkOutput("reset_cmd_ready", bus.cmd_ready, 0);
    checkOutput("reset_res_valid", bus.res_valid, 0);
    checkOutput("reset_in_sel", bus.alu_in_sel, 3'b001);
    checkOutput("reset_alu_on", bus.alu_on, 0);
    chkEn = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single add, latency and ALU select sequence.
    applyStimulus(1, 8'h57, 8'h1A, OP_ADD, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) checkOutput("t1_load_sel", bus.alu_in_sel, 3'b010);
      if (i == 2) checkOutput("t1_hold_sel", bus.alu_in_sel, 3'b100);
      if (bus.res_valid) begin
        n = i;
        break;
      end
    end
    checkOutput("t1_latency", n, 4);
    checkOutput("t1_data", bus.res_data, 8'h71);
    checkOutput("t1_err", bus.res_err, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1_accepted", bus.res_valid, 0);

    // Illegal ops produce error results without ever loading the ALU.
    applyStimulus(1, 8'h11, 8'h22, 7'b0000000, 1, 0);
    tick();
    applyStimulus(1, 8'h33, 8'h44, 7'b0000011, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0);
    n = 0;
    loads = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.res_valid && bus.res_err && (bus.res_data == 8'h00)) n++;
      if (bus.alu_in_sel == 3'b010) loads++;
      tick();
    end
    checkOutput("t2_err_results", n, 2);
    checkOutput("t2_no_load", loads, 0);

    // Subtract with consumer always ready: one valid cycle per command.
    applyStimulus(1, 8'h02, 8'h04, OP_SUB, 1, 0);
    tick();
    applyStimulus(1, 8'h10, 8'h01, OP_SUB, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0);
    vldCycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.res_valid && vldCycles < 8) begin
        got[vldCycles] = bus.res_data;
        vldCycles++;
      end
      tick();
    end
    checkOutput("t3_valid_cycles", vldCycles, 2);
    checkOutput("t3_first", got[0], 8'hFE);
    checkOutput("t3_second", got[1], 8'h0F);

    // Back-to-back pushes against a stalled consumer, then in-order drain.
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 8'(16 * (k + 1)), 8'(k + 1), OP_ADD, 0, 0);
      if (bus.cmd_ready) accepted++;
      tick();
    end
    checkOutput("t4_accepted", accepted, 5);
    checkOutput("t4_full_count", fifoCount, 4);
    checkOutput("t4_ready_low", bus.cmd_ready, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idx = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.res_valid && idx < 8) begin
        got[idx] = bus.res_data;
        idx++;
      end
      tick();
    end
    checkOutput("t4_result_count", idx, 5);
    for (int j = 0; j < 5; j++) checkOutput("t4_order", got[j], expOrder[j]);

    // Flush on a full FIFO with a command offered.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 8'(k + 3), 8'(k + 7), OP_ADD, 0, 0);
      tick();
    end
    checkOutput("t5_full", fifoCount, 4);
    applyStimulus(1, 8'hAA, 8'h55, OP_ADD, 0, 1);
    checkOutput("t5_ready_on_flush", bus.cmd_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("t5_count_cleared", fifoCount, 0);
    checkOutput("t5_res_cleared", bus.res_valid, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.res_valid) n++;
    end
    checkOutput("t5_no_result", n, 0);

    // Asynchronous reset while a command is in HOLD with two queued.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 8'(k + 1), 8'(k + 2), OP_ADD, 0, 0);
      tick();
    end
    checkOutput("t6_queued", fifoCount, 2);
    checkOutput("t6_hold_sel", bus.alu_in_sel, 3'b100);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("t6_count", fifoCount, 0);
    checkOutput("t6_res_valid", bus.res_valid, 0);
    checkOutput("t6_res_data", bus.res_data, 8'h00);
    checkOutput("t6_res_err", bus.res_err, 0);
    checkOutput("t6_alu_on", bus.alu_on, 0);
    checkOutput("t6_in_sel", bus.alu_in_sel, 3'b001);
    checkOutput("t6_num1", bus.alu_num1, 8'h00);
    checkOutput("t6_out_sel", bus.alu_out_sel, 7'h00);
    checkOutput("t6_cmd_ready", bus.cmd_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.res_valid) n++;
    end
    checkOutput("t6_no_result", n, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int         r;
      logic [6:0] op;
      r = $urandom_range(0, 99);
      if (r < 35)      op = OP_ADD;
      else if (r < 60) op = OP_SUB;
      else if (r < 75) op = 7'(1 << $urandom_range(0, 4));
      else if (r < 85) op = 7'b0000000;
      else             op = 7'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), op,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      tick();
    end

    chkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
